// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab3 seven-segment display path.
// The segment map is active-low {g,f,e,d,c,b,a}, which suits a common-anode display.
package lab3_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t       SEG_OFF   = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    function automatic seg_t hex7(input logic [3:0] nib);
        seg_t s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lab3_seven_segment_scanner_hex.sv
// Combinational nibble-to-segment decoder.
// It is kept as its own module so that it can be unit-tested in isolation.
module lab3_hex_to_7seg
    import lab3_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex7(nib);
    end

endmodule

// File: rtl/lab3_seven_segment_scanner.sv
// Time-multiplexed 4-digit hex scanner for a common-anode display.
// It takes a per-frame snapshot of the value, blanks leading zeros, and opens a guard gap at each digit switch.
module lab3_seven_segment_scanner
    import lab3_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100_000,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned   CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD = CW'(GUARD_CYCLES);

    logic [CW-1:0] div_cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;

    logic          tick;
    logic          guard;
    logic          upper_zero;
    logic          lz_blank;
    logic [3:0]    nib;
    logic [6:0]    nib_seg;

    always_comb begin
        tick  = (div_cnt == LAST);
        guard = (div_cnt < GUARD);
        nib   = shadow[{idx, 2'b00} +: 4];
        // A digit is a leading zero only if it and every digit above it are zero.
        unique case (idx)
            2'd1:    upper_zero = (shadow[15:4]  == '0);
            2'd2:    upper_zero = (shadow[15:8]  == '0);
            2'd3:    upper_zero = (shadow[15:12] == '0);
            default: upper_zero = 1'b0;
        endcase
        lz_blank = blank_lz & upper_zero;
    end

    lab3_hex_to_7seg u_dec (
        .nib (nib),
        .seg (nib_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            idx        <= '0;
            shadow     <= value;
            anode      <= ANODE_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end

            frame_done <= tick && (idx == 2'd3);
            if (tick && (idx == 2'd3)) begin
                shadow <= value;
            end

            if (guard || lz_blank) begin
                anode <= ANODE_OFF;
                seg   <= SEG_OFF;
                dp    <= 1'b1;
            end else begin
                anode <= ~(4'b0001 << idx);
                seg   <= nib_seg;
                dp    <= ~dp_in[idx];
            end
        end
    end

endmodule

// File: tb/tb_lab3_seven_segment_scanner.sv
// Self-checking bench for lab3_seven_segment_scanner.
// A cycle-position model predicts the outputs, and directed literal checks pin that model.
module tb_lab3_seven_segment_scanner;

    localparam int R = 8;
    localparam int G = 2;
    localparam int FRAME = 4 * R;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    lab3_seven_segment_scanner #(
        .REFRESH_DIV  (R),
        .GUARD_CYCLES (G)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] an_tab [4]   = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // The model is keyed on the number of cycles since the last reset edge.
    // The registered outputs show the position held just before each edge.
    int          p;
    bit          m_valid = 0;
    logic [15:0] m_shadow;
    logic [3:0]  e_anode;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    always @(posedge clk) begin
        if (reset) begin
            p = 0;
            m_shadow = value;
            m_valid = 1;
            e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else if (m_valid) begin
            int sidx, d;
            logic [15:0] upper;
            sidx  = (p / R) % 4;
            d     = p % R;
            upper = m_shadow >> (4 * sidx);
            if (d < G || (blank_lz && sidx != 0 && upper == 16'h0)) begin
                e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_anode = an_tab[sidx];
                e_seg   = hex_tab[upper[3:0]];
                e_dp    = ~dp_in[sidx];
            end
            e_fd = ((p % FRAME) == FRAME - 1);
            if (e_fd) m_shadow = value;
            p++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("anode", {12'h0, anode}, {12'h0, e_anode});
            check("seg", {9'h0, seg}, {9'h0, e_seg});
            check("dp", {15'h0, dp}, {15'h0, e_dp});
            check("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
            check("one_anode_max", 16'($countones(~anode) <= 1), 16'h1);
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Advance at least one cycle, until the position within the frame equals target.
    task automatic goto(input int target);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((cyc % FRAME) != target && n < 2 * FRAME);
        check("goto_bound", 16'(n < 2 * FRAME), 16'h1);
    endtask

    task automatic lit(input string name, input logic [3:0] an, input logic [6:0] sg);
        check({name, "_anode"}, {12'h0, anode}, {12'h0, an});
        check({name, "_seg"}, {9'h0, seg}, {9'h0, sg});
    endtask

    initial begin
        reset = 1'b1; value = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("reset", 4'hF, 7'h7F);
            check("reset_dp", {15'h0, dp}, 16'h1);
            check("reset_fd", {15'h0, frame_done}, 16'h0);
        end
        reset = 1'b0; cyc = 0;

        // Basic scan of 1234
        goto(2); lit("guard_d0", 4'hF, 7'h7F);
        goto(3); lit("digit0_4", 4'hE, 7'h19);
        goto(11); lit("digit1_3", 4'hD, 7'h30);
        goto(19); lit("digit2_2", 4'hB, 7'h24);
        goto(27); lit("digit3_1", 4'h7, 7'h79);
        goto(31); check("fd_before", {15'h0, frame_done}, 16'h0);
        goto(0);  check("fd_first", {15'h0, frame_done}, 16'h1);

        // A mid-frame value change does not appear until the next frame
        goto(10); value = 16'hABCD;
        goto(19); lit("old_digit2", 4'hB, 7'h24);
        goto(27); lit("old_digit3", 4'h7, 7'h79);
        goto(3);  lit("new_digit0_d", 4'hE, 7'h21);
        goto(11); lit("new_digit1_C", 4'hD, 7'h46);
        goto(27); lit("new_digit3_A", 4'h7, 7'h08);

        // Leading-zero blanking
        blank_lz = 1'b1; value = 16'h0005;
        goto(0); goto(3); lit("lz5_d0", 4'hE, 7'h12);
        goto(11); lit("lz5_d1", 4'hF, 7'h7F);
        goto(27); lit("lz5_d3", 4'hF, 7'h7F);
        value = 16'h0000;
        goto(0); goto(3); lit("lz0_d0", 4'hE, 7'h40);
        goto(19); lit("lz0_d2", 4'hF, 7'h7F);
        value = 16'h0500;
        goto(0); goto(11); lit("lz500_d1", 4'hD, 7'h40);
        goto(19); lit("lz500_d2", 4'hB, 7'h12);
        goto(27); lit("lz500_d3", 4'hF, 7'h7F);

        // Decimal point on digit 2 only
        blank_lz = 1'b0; dp_in = 4'b0100; value = 16'hFFFF;
        goto(0); goto(3); check("dp_d0", {15'h0, dp}, 16'h1);
        goto(19); lit("dpF_d2", 4'hB, 7'h0E); check("dp_d2", {15'h0, dp}, 16'h0);
        goto(27); check("dp_d3", {15'h0, dp}, 16'h1);

        // Reset in the middle of the digit-2 slot
        dp_in = 4'h0; value = 16'h9876;
        goto(18);
        reset = 1'b1;
        tick();
        lit("midreset", 4'hF, 7'h7F);
        check("midreset_fd", {15'h0, frame_done}, 16'h0);
        reset = 1'b0; cyc = 0;
        goto(1); lit("rel_guard1", 4'hF, 7'h7F);
        goto(2); lit("rel_guard2", 4'hF, 7'h7F);
        goto(3); lit("rel_digit0_6", 4'hE, 7'h02);
        goto(11); lit("rel_digit1_7", 4'hD, 7'h78);
        goto(31); check("rel_fd_before", {15'h0, frame_done}, 16'h0);
        goto(0);  check("rel_fd_32", {15'h0, frame_done}, 16'h1);
        goto(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
